// File: rtl/xilinx_phy10g_quad_reset_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : xilinx_phy10g_quad_reset_ctrl                               |
// | Description: QPLL reset/lock supervision plus round-robin per-lane GT    |
// |              reset sequencing for one 10G transceiver quad.              |
// |              Optional lock_ok filter: define PHY10G_LOCK_FILTER_EN.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module xilinx_phy10g_quad_reset_ctrl #(
  parameter int QPLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int LANE_RST_CYCLES = 8,
  parameter int DONE_TIMEOUT    = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       qplllock_i,
  output logic       qpllreset_o,
  input  logic [3:0] lane_rst_req_i,
  output logic [3:0] lane_rst_ack_o,
  output logic [3:0] gt_reset_o,
  input  logic [3:0] gt_resetdone_i,
  output logic [3:0] lane_fail_o,
  output logic [3:0] lanes_ready_o,
  output logic [7:0] lock_lost_cnt_o
);

  localparam int c_max_ab = (QPLL_RST_CYCLES > LOCK_TIMEOUT) ? QPLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_max_cd = (LANE_RST_CYCLES > DONE_TIMEOUT) ? LANE_RST_CYCLES : DONE_TIMEOUT;
  localparam int c_cnt_max = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_qrst_last = c_cnt_w'(QPLL_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_lrst_last = c_cnt_w'(LANE_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_done_last = c_cnt_w'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_QRST  = 3'd0,
    S_QWAIT = 3'd1,
    S_IDLE  = 3'd2,
    S_LRST  = 3'd3,
    S_LWAIT = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_lock_meta;
  logic                 r_lock_sync;
  logic                 r_qpllreset;
  logic [3:0]           r_ack;
  logic [3:0]           r_gt_reset;
  logic [3:0]           r_fail;
  logic [3:0]           r_ready;
  logic [7:0]           r_lost_cnt;
  logic [1:0]           r_grant;
  logic [1:0]           r_last_grant;

  logic                 w_lock_ok;
  logic                 w_lock_drop;
  logic                 w_grant_hit;
  logic [1:0]           w_grant_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= qplllock_i;
      r_lock_sync <= r_lock_meta;
    end
  end

`ifdef PHY10G_LOCK_FILTER_EN
  // Counts consecutive synchronized-high cycles already seen, saturating at 15.
  logic [3:0] r_filt_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filt_cnt <= 4'd0;
    end else if (!r_lock_sync) begin
      r_filt_cnt <= 4'd0;
    end else if (r_filt_cnt != 4'd15) begin
      r_filt_cnt <= r_filt_cnt + 4'd1;
    end
  end

  assign w_lock_ok = r_lock_sync & (r_filt_cnt == 4'd15);
`else
  assign w_lock_ok = r_lock_sync;
`endif

  assign w_lock_drop = !w_lock_ok &&
                       (r_state == S_IDLE || r_state == S_LRST || r_state == S_LWAIT);

  // Round-robin search from last_grant+1; descending loop lets the nearest lane win.
  always_comb begin
    w_grant_hit = 1'b0;
    w_grant_idx = r_last_grant;
    for (int k = 3; k >= 0; k--) begin
      if (lane_rst_req_i[r_last_grant + 2'(k) + 2'd1]) begin
        w_grant_hit = 1'b1;
        w_grant_idx = r_last_grant + 2'(k) + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_QRST;
      r_cnt        <= '0;
      r_qpllreset  <= 1'b1;
      r_ack        <= 4'd0;
      r_gt_reset   <= 4'd0;
      r_fail       <= 4'd0;
      r_ready      <= 4'd0;
      r_lost_cnt   <= 8'd0;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd3;
    end else begin
      r_ack <= 4'd0;
      if (r_state == S_QRST || r_state == S_QWAIT) begin
        r_ready <= 4'd0;
      end else begin
        r_ready <= {4{w_lock_ok}} & gt_resetdone_i & ~r_gt_reset;
      end

      if (w_lock_drop) begin
        // Lock loss aborts any lane sequence; the request stays pending for a later grant.
        r_state     <= S_QRST;
        r_cnt       <= '0;
        r_qpllreset <= 1'b1;
        r_gt_reset  <= 4'd0;
        if (r_lost_cnt != 8'hFF) begin
          r_lost_cnt <= r_lost_cnt + 8'd1;
        end
      end else begin
        case (r_state)
          S_QRST: begin
            if (r_cnt == c_qrst_last) begin
              r_state     <= S_QWAIT;
              r_cnt       <= '0;
              r_qpllreset <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_QWAIT: begin
            if (w_lock_ok) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_lock_last) begin
              r_state     <= S_QRST;
              r_cnt       <= '0;
              r_qpllreset <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (w_grant_hit) begin
              r_state      <= S_LRST;
              r_cnt        <= '0;
              r_grant      <= w_grant_idx;
              r_last_grant <= w_grant_idx;
              r_gt_reset   <= 4'b0001 << w_grant_idx;
            end
          end
          S_LRST: begin
            if (r_cnt == c_lrst_last) begin
              r_state    <= S_LWAIT;
              r_cnt      <= '0;
              r_gt_reset <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_LWAIT: begin
            if (gt_resetdone_i[r_grant]) begin
              r_state         <= S_IDLE;
              r_cnt           <= '0;
              r_ack[r_grant]  <= 1'b1;
              r_fail[r_grant] <= 1'b0;
            end else if (r_cnt == c_done_last) begin
              r_state         <= S_IDLE;
              r_cnt           <= '0;
              r_ack[r_grant]  <= 1'b1;
              r_fail[r_grant] <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state     <= S_QRST;
            r_cnt       <= '0;
            r_qpllreset <= 1'b1;
            r_gt_reset  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign qpllreset_o     = r_qpllreset;
  assign lane_rst_ack_o  = r_ack;
  assign gt_reset_o      = r_gt_reset;
  assign lane_fail_o     = r_fail;
  assign lanes_ready_o   = r_ready;
  assign lock_lost_cnt_o = r_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xilinx_phy10g_quad_reset_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_xilinx_phy10g_quad_reset_ctrl                            |
// | Description: Randomized self-checking bench for the quad reset control.  |
// |              Filter scenario enabled with PHY10G_LOCK_FILTER_EN.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_xilinx_phy10g_quad_reset_ctrl;

  localparam int QRST = 16;
  localparam int LTO  = 300;
  localparam int LRST = 8;
  localparam int DTO  = 100;
  localparam int P    = QRST + LTO;
`ifdef PHY10G_LOCK_FILTER_EN
  localparam int LOCK_LAT = 18;
`else
  localparam int LOCK_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       qplllock = 1'b0;
  logic [3:0] lane_rst_req = 4'd0;
  logic [3:0] gt_resetdone = 4'hF;
  logic       qpllreset_o;
  logic [3:0] lane_rst_ack_o;
  logic [3:0] gt_reset_o;
  logic [3:0] lane_fail_o;
  logic [3:0] lanes_ready_o;
  logic [7:0] lock_lost_cnt_o;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int m_last = 3;
  logic [3:0] m_fail = 4'd0;
  int m_lost = 0;

  xilinx_phy10g_quad_reset_ctrl #(
    .QPLL_RST_CYCLES(QRST),
    .LOCK_TIMEOUT(LTO),
    .LANE_RST_CYCLES(LRST),
    .DONE_TIMEOUT(DTO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .qplllock_i(qplllock),
    .qpllreset_o(qpllreset_o),
    .lane_rst_req_i(lane_rst_req),
    .lane_rst_ack_o(lane_rst_ack_o),
    .gt_reset_o(gt_reset_o),
    .gt_resetdone_i(gt_resetdone),
    .lane_fail_o(lane_fail_o),
    .lanes_ready_o(lanes_ready_o),
    .lock_lost_cnt_o(lock_lost_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference arbitration: first pending lane after the last grant, wrapping.
  function automatic int rr_pick(input logic [3:0] pend, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (pend[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc = cyc + 1;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    qplllock = 1'b0;
    lane_rst_req = 4'd0;
    gt_resetdone = 4'hF;
    #1;
    if (chk) begin
      n_checks++;
      if (qpllreset_o !== 1'b1) $display("FAIL rst_qpllreset got=%b exp=1", qpllreset_o);
      else n_pass++;
      n_checks++;
      if ({lane_rst_ack_o, gt_reset_o, lane_fail_o, lanes_ready_o} !== 16'd0)
        $display("FAIL rst_lane_outputs got=%h exp=0000",
                 {lane_rst_ack_o, gt_reset_o, lane_fail_o, lanes_ready_o});
      else n_pass++;
      n_checks++;
      if (lock_lost_cnt_o !== 8'd0) $display("FAIL rst_lost_cnt got=%0d exp=0", lock_lost_cnt_o);
      else n_pass++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    m_last = 3;
    m_fail = 4'd0;
    m_lost = 0;
  endtask

  task automatic bring_up();
    do_reset(1'b0);
    while (cyc < 40) tick();
    qplllock = 1'b1;
    while (cyc < 40 + LOCK_LAT + 1) tick();
  endtask

  // Serve one expected grant: resetdone returns `delay` cycles into LWAIT (never if too late).
  task automatic serve(input int lane, input int delay, input int glitch);
    int i, w, e, ack_cyc;
    logic [3:0] oh;
    logic exp_fail;
    oh = 4'b0001 << lane;
    for (i = 0; gt_reset_o === 4'd0 && i < 200; i++) tick();
    n_checks++;
    if (gt_reset_o !== oh) begin
      $display("FAIL grant_lane got=%b exp=%b cyc=%0d", gt_reset_o, oh, cyc);
      if (gt_reset_o === 4'd0) return;
    end else n_pass++;
    m_last = lane;
    gt_resetdone[lane] = 1'b0;
    w = 0;
    while (gt_reset_o === oh && w < 100) begin
      w++;
      if (w == 4) begin
        n_checks++;
        if (lanes_ready_o !== (gt_resetdone & ~oh))
          $display("FAIL ready_in_lrst got=%b exp=%b", lanes_ready_o, gt_resetdone & ~oh);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (w != LRST || gt_reset_o !== 4'd0)
      $display("FAIL gt_reset_width got=%0d exp=%0d", w, LRST);
    else n_pass++;
    e = cyc;
    if (delay + 1 <= DTO) begin
      ack_cyc = e + delay + 1;
      exp_fail = 1'b0;
    end else begin
      ack_cyc = e + DTO;
      exp_fail = 1'b1;
    end
    while (cyc < ack_cyc) begin
      if (cyc - e == delay) gt_resetdone[lane] = 1'b1;
      if (glitch >= 0 && cyc == e) lane_rst_req[glitch] = 1'b1;
      if (glitch >= 0 && cyc == e + 2) lane_rst_req[glitch] = 1'b0;
      if (cyc == ack_cyc - 1) begin
        n_checks++;
        if (lane_rst_ack_o !== 4'd0) $display("FAIL ack_early got=%b exp=0000", lane_rst_ack_o);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (lane_rst_ack_o !== oh) $display("FAIL ack_pulse got=%b exp=%b cyc=%0d", lane_rst_ack_o, oh, cyc);
    else n_pass++;
    lane_rst_req[lane] = 1'b0;
    gt_resetdone[lane] = 1'b1;
    m_fail[lane] = exp_fail;
    tick();
    n_checks++;
    if (lane_rst_ack_o !== 4'd0) $display("FAIL ack_width got=%b exp=0000", lane_rst_ack_o);
    else n_pass++;
    n_checks++;
    if (lane_fail_o !== m_fail) $display("FAIL lane_fail got=%b exp=%b", lane_fail_o, m_fail);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    while (cyc <= 20) begin
      n_checks++;
      if (qpllreset_o !== (cyc < QRST)) $display("FAIL qrst_pulse cyc=%0d got=%b exp=%b", cyc, qpllreset_o, cyc < QRST);
      else n_pass++;
      tick();
    end
    while (cyc < 40) tick();
    qplllock = 1'b1;
    while (cyc < 40 + LOCK_LAT) tick();
    n_checks++;
    if (lanes_ready_o !== 4'd0) $display("FAIL ready_before_idle got=%b exp=0000", lanes_ready_o);
    else n_pass++;
    tick();
    n_checks++;
    if (lanes_ready_o !== 4'hF) $display("FAIL ready_after_idle got=%b exp=1111", lanes_ready_o);
    else n_pass++;
  endtask

  task automatic test_lock_timeout();
    do_reset(1'b0);
    while (cyc <= 2 * P + 20) begin
      n_checks++;
      if (qpllreset_o !== ((cyc % P) < QRST))
        $display("FAIL qpll_repulse cyc=%0d got=%b exp=%b", cyc, qpllreset_o, (cyc % P) < QRST);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (lock_lost_cnt_o !== 8'd0) $display("FAIL lost_cnt_nolock got=%0d exp=0", lock_lost_cnt_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bring_up();
    lane_rst_req = 4'hF;
    for (int n = 0; n < 4; n++) serve(rr_pick(lane_rst_req, m_last), int'($urandom_range(0, 20)), -1);
    tick();
    n_checks++;
    if (lanes_ready_o !== 4'hF) $display("FAIL ready_after_rr got=%b exp=1111", lanes_ready_o);
    else n_pass++;
  endtask

  task automatic test_timeout_fail();
    lane_rst_req[2] = 1'b1;
    serve(rr_pick(lane_rst_req, m_last), DTO + 50, -1);
    lane_rst_req[2] = 1'b1;
    serve(rr_pick(lane_rst_req, m_last), 5, -1);
  endtask

  task automatic test_drop();
    lane_rst_req = 4'b0001;
    serve(rr_pick(lane_rst_req, m_last), 10, 3);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (gt_reset_o !== 4'd0) $display("FAIL dropped_req_granted got=%b exp=0000", gt_reset_o);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lock_loss();
    int i, c;
    lane_rst_req = 4'b0010;
    for (i = 0; gt_reset_o === 4'd0 && i < 100; i++) tick();
    n_checks++;
    if (gt_reset_o !== 4'b0010) $display("FAIL abort_lrst_grant got=%b exp=0010", gt_reset_o);
    else n_pass++;
    tick();
    tick();
    qplllock = 1'b0;
    c = cyc;
    while (cyc < c + 2) tick();
    n_checks++;
    if ({qpllreset_o, gt_reset_o} !== 5'b00010) $display("FAIL abort_lrst_pre got=%b exp=00010", {qpllreset_o, gt_reset_o});
    else n_pass++;
    tick();
    m_lost++;
    n_checks++;
    if ({qpllreset_o, gt_reset_o} !== 5'b10000) $display("FAIL abort_lrst_post got=%b exp=10000", {qpllreset_o, gt_reset_o});
    else n_pass++;
    n_checks++;
    if (lock_lost_cnt_o !== 8'(m_lost)) $display("FAIL abort_lrst_cnt got=%0d exp=%0d", lock_lost_cnt_o, m_lost);
    else n_pass++;
    qplllock = 1'b1;
    // Regrant of the still-pending lane, then abort during LWAIT.
    for (i = 0; gt_reset_o === 4'd0 && i < 200; i++) tick();
    n_checks++;
    if (gt_reset_o !== 4'b0010) $display("FAIL abort_lwait_grant got=%b exp=0010", gt_reset_o);
    else n_pass++;
    gt_resetdone[1] = 1'b0;
    for (i = 0; gt_reset_o !== 4'd0 && i < 100; i++) tick();
    tick();
    tick();
    qplllock = 1'b0;
    c = cyc;
    while (cyc < c + 3) begin
      tick();
    end
    m_lost++;
    n_checks++;
    if (qpllreset_o !== 1'b1 || lock_lost_cnt_o !== 8'(m_lost))
      $display("FAIL abort_lwait got=%b/%0d exp=1/%0d", qpllreset_o, lock_lost_cnt_o, m_lost);
    else n_pass++;
    while (cyc < c + 14) begin
      n_checks++;
      if ({lane_rst_ack_o, gt_reset_o, lanes_ready_o} !== 12'd0)
        $display("FAIL abort_quiet got=%h exp=000", {lane_rst_ack_o, gt_reset_o, lanes_ready_o});
      else n_pass++;
      tick();
    end
    qplllock = 1'b1;
    serve(rr_pick(lane_rst_req, m_last), 4, -1);
  endtask

  task automatic test_random();
    int d;
    for (int r = 0; r < 12; r++) begin
      if (lane_rst_req == 4'd0) begin
        lane_rst_req = 4'($urandom_range(1, 15));
      end
      d = ($urandom_range(0, 3) == 0) ? DTO + 7 : int'($urandom_range(0, 40));
      serve(rr_pick(lane_rst_req, m_last), d, -1);
    end
    while (lane_rst_req != 4'd0) serve(rr_pick(lane_rst_req, m_last), 1, -1);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 258; n++) begin
      qplllock = 1'b0;
      repeat (4) tick();
      m_lost = (m_lost < 255) ? m_lost + 1 : 255;
      n_checks++;
      if (lock_lost_cnt_o !== 8'(m_lost)) $display("FAIL lost_cnt_sat got=%0d exp=%0d", lock_lost_cnt_o, m_lost);
      else n_pass++;
      qplllock = 1'b1;
      repeat (QRST + LOCK_LAT + 4) tick();
    end
  endtask

  task automatic test_reset_mid();
    int i;
    lane_rst_req = 4'b0100;
    for (i = 0; gt_reset_o === 4'd0 && i < 100; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({qpllreset_o, gt_reset_o, lock_lost_cnt_o, lane_fail_o} !== {1'b1, 4'd0, 8'd0, 4'd0})
      $display("FAIL reset_mid got=%b/%b/%0d/%b exp=1/0000/0/0000",
               qpllreset_o, gt_reset_o, lock_lost_cnt_o, lane_fail_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    m_last = 3;
    m_fail = 4'd0;
    m_lost = 0;
    serve(rr_pick(lane_rst_req, m_last), 3, -1);
  endtask

`ifdef PHY10G_LOCK_FILTER_EN
  task automatic test_lock_filter();
    do_reset(1'b0);
    while (cyc < 40) tick();
    qplllock = 1'b1;
    repeat (10) tick();
    qplllock = 1'b0;
    while (cyc < 100) begin
      tick();
      n_checks++;
      if (lanes_ready_o !== 4'd0) $display("FAIL filter_glitch got=%b exp=0000", lanes_ready_o);
      else n_pass++;
    end
    qplllock = 1'b1;
    while (cyc < 100 + LOCK_LAT + 1) begin
      n_checks++;
      if (lanes_ready_o !== 4'd0) $display("FAIL filter_early got=%b exp=0000", lanes_ready_o);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (lanes_ready_o !== 4'hF) $display("FAIL filter_lock got=%b exp=1111", lanes_ready_o);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_lock_timeout();
    test_round_robin();
    test_timeout_fail();
    test_drop();
    test_lock_loss();
    test_random();
    test_saturate();
    test_reset_mid();
`ifdef PHY10G_LOCK_FILTER_EN
    test_lock_filter();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xilinx_phy10g_quad_reset_ctrl.md
XILINX_PHY10G_QUAD_RESET_CTRL -- requirements
Module: xilinx_phy10g_quad_reset_ctrl

Interface
REQ-001 SHALL have parameter QPLL_RST_CYCLES, default 16, meaning qpllreset_o pulse width in clk_i cycles (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, meaning cycles to wait for lock before re-issuing QPLL reset.
REQ-003 SHALL have parameter LANE_RST_CYCLES, default 8, meaning gt_reset_o pulse width in cycles (>=1).
REQ-004 SHALL have parameter DONE_TIMEOUT, default 4096, meaning cycles to wait for lane reset-done.
REQ-005 SHALL have port clk_i  input  1  single block clock, all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port qplllock_i  input  1  QPLL lock, asynchronous to clk_i.
REQ-008 SHALL have port qpllreset_o  output  1  QPLL reset to quad common block.
REQ-009 SHALL have port lane_rst_req_i  input  4  per-lane level reset request, held until ack.
REQ-010 SHALL have port lane_rst_ack_o  output  4  one-cycle completion pulse per lane.
REQ-011 SHALL have port gt_reset_o  output  4  per-lane GT reset, at most one bit set.
REQ-012 SHALL have port gt_resetdone_i  input  4  per-lane reset-done, already synchronous to clk_i.
REQ-013 SHALL have port lane_fail_o  output  4  sticky per-lane reset-done timeout flag.
REQ-014 SHALL have port lanes_ready_o  output  4  lane usable: lock_ok, resetdone, not in reset.
REQ-015 SHALL have port lock_lost_cnt_o  output  8  saturating count of lock losses after first lock.

Function
REQ-016 SHALL synchronize qplllock_i through two flops; lock_ok derives only from the synchronized value.
REQ-017 SHALL implement FSM states QRST, QWAIT, IDLE, LRST, LWAIT with one shared cycle counter cleared on every state entry.
REQ-018 QRST: qpllreset_o=1; after QPLL_RST_CYCLES cycles SHALL go to QWAIT with qpllreset_o=0.
REQ-019 QWAIT: lock_ok -> IDLE; counter reaching LOCK_TIMEOUT first -> QRST; lock_ok on the timeout cycle SHALL win.
REQ-020 IDLE: loss of lock_ok -> QRST and lock_lost_cnt_o += 1 (saturating at 255), taking priority over requests.
REQ-021 IDLE with any request pending SHALL grant one lane round-robin, search starting at (last granted + 1) mod 4, initial last granted = 3, and go to LRST.
REQ-022 LRST: gt_reset_o[granted]=1 for exactly LANE_RST_CYCLES cycles, then LWAIT.
REQ-023 LWAIT: gt_resetdone_i[granted]=1 -> ack pulse, clear lane_fail_o[granted], IDLE; counter reaching DONE_TIMEOUT -> ack pulse, set lane_fail_o[granted], IDLE.
REQ-024 Loss of lock_ok in LRST or LWAIT SHALL abort: gt_reset_o cleared next cycle, no ack, lock_lost_cnt_o incremented, go to QRST; request stays pending.
REQ-025 Requests deasserted before grant SHALL be dropped silently; lane_rst_req_i is ignored outside IDLE.
REQ-026 lanes_ready_o[i] SHALL be registered (1-cycle latency) = lock_ok & gt_resetdone_i[i] & ~gt_reset_o[i], and 0 in QRST/QWAIT.
REQ-027 All outputs SHALL be registered; lane_rst_ack_o bits SHALL be high for exactly one cycle.

Reset
REQ-028 rst_ni low SHALL asynchronously force state QRST, counter 0, qpllreset_o=1, gt_reset_o=0, lane_rst_ack_o=0, lanes_ready_o=0, lane_fail_o=0, lock_lost_cnt_o=0, last granted=3, synchronizer flops 0.
REQ-029 Release of rst_ni SHALL start the QRST pulse count from zero; reset mid-sequence SHALL discard any grant.

Configuration
REQ-030 With PHY10G_LOCK_FILTER_EN defined, lock_ok SHALL rise only after the synchronized lock is high 16 consecutive cycles and fall on the first low cycle.
REQ-031 Without PHY10G_LOCK_FILTER_EN, lock_ok SHALL equal the synchronized lock directly (no filter logic instantiated).

Verification
REQ-032 Reset release, qplllock_i rises at cycle 40 -> qpllreset_o high cycles 0-15, IDLE reached 3 cycles (unfiltered) after lock rise.
REQ-033 qplllock_i held low -> qpllreset_o repulses every QPLL_RST_CYCLES+LOCK_TIMEOUT cycles; lock_lost_cnt_o stays 0.
REQ-034 In IDLE, lane_rst_req_i=4'b1111 held -> grants in order 0,1,2,3, each gt_reset_o pulse 8 cycles, ack after resetdone.
REQ-035 gt_resetdone_i[2] stuck low -> ack[2] after 8+4096 cycles, lane_fail_o[2]=1; later successful reset clears it.
REQ-036 Drop qplllock_i during LWAIT of lane 1 -> gt_reset_o=0, no ack[1], lock_lost_cnt_o=1, QRST; after relock lane 1 re-granted.
REQ-037 With PHY10G_LOCK_FILTER_EN, 10-cycle lock glitch -> no IDLE entry; 16-cycle stable lock -> IDLE.
